graph_capture: RTL and testbench
================================

// Module: graph_capture
// PURPOSE
//  Successor to the fixed 5-trace display. Triggered logic-analyser trace renderer: captures CHANNELS x
//  2-bit state samples into an on-chip sample buffer and redraws them as scrolling-free waveforms
//  behind the VGA pixel scanner. Adds capture FSM, trigger, single/continuous modes, per-column transitions.
// PARAMETERS
//  CHANNELS   5     number of traces
//  SAMPLES    640   buffer depth = displayed columns; power of 2 not required
//  X_SCALE    2     pixels per sample column, 1..8
//  TRACE_H    10    band height in lines, >=3
//  Y0         10    top line of channel 0 band
//  PITCH      30    line offset between bands, >= TRACE_H
//  H_RES      1280  active width; SAMPLES*X_SCALE <= H_RES
// PORTS
//  clk           in   1             pixel clock; one x step per cycle in active region
//  rst           in   1             synchronous active-low reset
//  x             in   11            scanner column
//  y             in   10            scanner line
//  sample_valid  in   1             qualifies sample this cycle
//  sample        in   2*CHANNELS    ch c at [2c+1:2c]; 00 low, 01 high, 10 Z, 11 X
//  arm           in   1             1-cycle pulse: start a capture
//  continuous    in   1             1: re-arm automatically after each completed capture
//  trig_mask     in   2*CHANNELS    bits compared for trigger
//  trig_value    in   2*CHANNELS    trigger pattern
//  rgb_out       out  3             pixel colour {r,g,b}
//  busy          out  1             high in ARMED or CAPTURE
//  done          out  1             high in HOLD, buffer fully valid
// BEHAVIOUR
//  Reset (rst==0 at edge): FSM->IDLE, wr_ptr=0, buf_valid=0, rgb_out=0, busy=0, done=0. RAM not cleared.
//  FSM: IDLE -arm-> ARMED; ARMED -(sample_valid & ((sample^trig_value)&trig_mask)==0)-> CAPTURE;
//   CAPTURE writes trigger sample at addr 0 same cycle, then each valid sample at wr_ptr+1;
//   after write to SAMPLES-1 -> HOLD, buf_valid=1; HOLD -(arm | continuous)-> ARMED.
//  trig_mask==0: first valid sample after arming triggers. arm in ARMED/CAPTURE ignored.
//  arm while in HOLD: buf_valid cleared on entry to ARMED (display blank until next completion).
//  Mid-capture reset: abandon, buf_valid=0; no partial frame ever displayed.
//  Render pipeline, total latency 2 clk from (x,y) to rgb_out:
//   st0: col = x / X_SCALE (counter-based, no divider: sub-count resets when x==0); RAM read addr=col.
//   st1: RAM data, prev column data register; draw; st2: rgb_out registered.
//  Channel c band: y in [Y0+c*PITCH, Y0+c*PITCH+TRACE_H). Row top=first line, bot=last line.
//  Draw per channel (outside all bands, x>=SAMPLES*X_SCALE, or buf_valid==0: 3'b000):
//   low  -> bot row green 3'b010; high -> top row green; Z -> middle line (TRACE_H/2) yellow 3'b110;
//   X -> whole band red 3'b100.
//   Transition: first pixel of a column with col!=0 and data!=prev -> full band height white 3'b111.
//  rgb_out = OR of all channel colours (bands must not overlap; not checked).
//  x jumping (blanking) allowed; prev register reloads at x==0 so column 0 never shows a transition.
//  Simultaneous CAPTURE write and render read: true dual-port RAM; render shows old frame until HOLD.
// STRUCTURE
//  Package graph_pkg: state codes ST_LOW/ST_HIGH/ST_Z/ST_X, colour constants, FSM state enum.
//  Sub-module graph_trace_pixel (one per channel, generate loop): band decode + draw, params py,by.
//  Sample RAM inferred inline (SAMPLES x 2*CHANNELS, 1-cycle read).
// TESTING
//  1 rst=0 2 clk mid-CAPTURE -> busy=0, done=0, rgb_out=0 for entire next frame.
//  2 arm, trig_mask=0, feed SAMPLES ramp pattern -> done after exactly SAMPLES valid samples; RAM[k]=k-th.
//  3 ch0 trig_mask=2'b11, value 01; stream 00x7 then 01 -> addr0 holds the 01 sample, pre-trigger lost.
//  4 ch0 00,00,01: at y=Y0+TRACE_H-1, x=0..3 -> rgb 010 two cycles later; x=4 (col2) at y=Y0 -> 111.
//  5 ch1 value 11 -> every y in [40,50) at its columns = 100; ch2 value 10 at y=75 -> 110.
//  6 continuous=1: after done, busy reasserts next cycle, previous frame stays blank until recapture.

Source files
------------

// File: rtl/graph_pkg.sv
// Shared constants for the triggered trace renderer:
// sample state codes, pixel colours and capture FSM states.
package graph_pkg;

   localparam logic [1:0] ST_LOW  = 2'b00;
   localparam logic [1:0] ST_HIGH = 2'b01;
   localparam logic [1:0] ST_Z    = 2'b10;
   localparam logic [1:0] ST_X    = 2'b11;

   localparam logic [2:0] C_BLACK  = 3'b000;
   localparam logic [2:0] C_GREEN  = 3'b010;
   localparam logic [2:0] C_YELLOW = 3'b110;
   localparam logic [2:0] C_RED    = 3'b100;
   localparam logic [2:0] C_WHITE  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_HOLD
   } cap_state_e;

endpackage

// File: rtl/graph_trace_pixel.sv
// One channel band: decodes whether the line falls in the band
// and picks the colour for the stored 2-bit state.
module graph_trace_pixel
   import graph_pkg::*;
#(
   parameter int PY = 10,
   parameter int BY = 19
) (
   input  logic [9:0] y,
   input  logic [1:0] data,
   input  logic       trans,
   input  logic       en,
   output logic [2:0] colour
);

   localparam logic [9:0] TOP = 10'(PY);
   localparam logic [9:0] BOT = 10'(BY);
   localparam logic [9:0] MID = 10'(PY + (BY - PY + 1) / 2);

   logic in_band;

   assign in_band = en && (y >= TOP) && (y <= BOT);

   // draw the state inside the band; a transition fills the band white
   always_comb begin
      colour = C_BLACK;
      if (in_band) begin
         if (trans) begin
            colour = C_WHITE;
         end else begin
            unique case (data)
               ST_LOW:  if (y == BOT) colour = C_GREEN;
               ST_HIGH: if (y == TOP) colour = C_GREEN;
               ST_Z:    if (y == MID) colour = C_YELLOW;
               default: colour = C_RED;
            endcase
         end
      end
   end

endmodule

// File: rtl/graph_capture.sv
// Triggered logic-analyser capture into a sample RAM, redrawn as
// per-channel waveforms behind the pixel scanner (2-clock latency).
module graph_capture
   import graph_pkg::*;
#(
   parameter int CHANNELS = 5,
   parameter int SAMPLES  = 640,
   parameter int X_SCALE  = 2,
   parameter int TRACE_H  = 10,
   parameter int Y0       = 10,
   parameter int PITCH    = 30,
   parameter int H_RES    = 1280
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [10:0]           x,
   input  logic [9:0]            y,
   input  logic                  sample_valid,
   input  logic [2*CHANNELS-1:0] sample,
   input  logic                  arm,
   input  logic                  continuous,
   input  logic [2*CHANNELS-1:0] trig_mask,
   input  logic [2*CHANNELS-1:0] trig_value,
   output logic [2:0]            rgb_out,
   output logic                  busy,
   output logic                  done
);

   localparam int DW = 2 * CHANNELS;
   localparam int AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
   localparam int SW = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
   localparam int XE = (SAMPLES * X_SCALE < H_RES) ? SAMPLES * X_SCALE : H_RES;
   localparam logic [AW-1:0] LAST     = AW'(SAMPLES - 1);
   localparam logic [SW-1:0] SUB_LAST = SW'(X_SCALE - 1);
   localparam logic [11:0]   X_END    = 12'(XE);

   cap_state_e    state;
   logic [AW-1:0] wr_ptr;
   logic          buf_valid;
   logic [DW-1:0] ram [SAMPLES];
   logic          trig_hit;
   logic          we;
   logic [AW-1:0] waddr;

   logic [AW-1:0] col_q, col;
   logic [SW-1:0] sub_q, sub;
   logic [DW-1:0] rd_data, prev_q;
   logic [9:0]    y1;
   logic          in1, first1;

   logic [CHANNELS-1:0] trans;
   logic [2:0]          ch_rgb [CHANNELS];
   logic [2:0]          rgb_any;

   assign trig_hit = sample_valid
                   && (((sample ^ trig_value) & trig_mask) == '0);

   // write port: trigger sample lands at 0, the rest follow wr_ptr
   always_comb begin
      we    = 1'b0;
      waddr = wr_ptr + AW'(1);
      if (state == S_ARMED) begin
         we    = trig_hit;
         waddr = '0;
      end else if (state == S_CAPTURE) begin
         we = sample_valid;
      end
   end

   // capture FSM with registered status outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         buf_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (arm) begin
                  state <= S_ARMED;
                  busy  <= 1'b1;
               end
            end
            S_ARMED: begin
               if (trig_hit) begin
                  wr_ptr <= '0;
                  if (LAST == '0) begin
                     state     <= S_HOLD;
                     buf_valid <= 1'b1;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state <= S_CAPTURE;
                  end
               end
            end
            S_CAPTURE: begin
               if (sample_valid) begin
                  wr_ptr <= waddr;
                  if (waddr == LAST) begin
                     state     <= S_HOLD;
                     buf_valid <= 1'b1;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            default: begin
               if (arm || continuous) begin
                  state     <= S_ARMED;
                  buf_valid <= 1'b0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
         endcase
      end
   end

   // sample RAM write port
   always_ff @(posedge clk) begin
      if (we) ram[waddr] <= sample;
   end

   // column tracking from the scan position, restarted at x == 0
   always_comb begin
      col = col_q;
      sub = sub_q + SW'(1);
      if (x == '0) begin
         col = '0;
         sub = '0;
      end else if (sub_q == SUB_LAST) begin
         sub = '0;
         if (col_q != LAST) col = col_q + AW'(1);
      end
   end

   // sample RAM read port, one cycle
   always_ff @(posedge clk) begin
      rd_data <= ram[col];
   end

   // stage-1 pixel context and previous-column data
   always_ff @(posedge clk) begin
      if (!rst) begin
         col_q  <= '0;
         sub_q  <= '0;
         y1     <= '0;
         in1    <= 1'b0;
         first1 <= 1'b0;
         prev_q <= '0;
      end else begin
         col_q  <= col;
         sub_q  <= sub;
         y1     <= y;
         in1    <= ({1'b0, x} < X_END);
         first1 <= (sub == '0) && (col != '0);
         prev_q <= rd_data;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign trans[c] = first1
                     && (rd_data[2*c +: 2] != prev_q[2*c +: 2]);

      graph_trace_pixel #(
         .PY (Y0 + c * PITCH),
         .BY (Y0 + c * PITCH + TRACE_H - 1)
      ) u_pix (
         .y      (y1),
         .data   (rd_data[2*c +: 2]),
         .trans  (trans[c]),
         .en     (buf_valid && in1),
         .colour (ch_rgb[c])
      );
   end

   // merge channel colours
   always_comb begin
      rgb_any = C_BLACK;
      for (int c = 0; c < CHANNELS; c++) begin
         rgb_any = rgb_any | ch_rgb[c];
      end
   end

   // stage-2 output register
   always_ff @(posedge clk) begin
      if (!rst) rgb_out <= C_BLACK;
      else      rgb_out <= rgb_any;
   end

endmodule

// File: tb/tb_graph_capture.sv
// Directed bench for graph_capture: capture FSM, trigger and
// rendering, checked through a pixel scoreboard.
module tb_graph_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] x;
   logic [9:0]  y;
   logic        sample_valid;
   logic [9:0]  sample;
   logic        arm;
   logic        continuous;
   logic [9:0]  trig_mask;
   logic [9:0]  trig_value;
   logic [2:0]  rgb_out;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic        probe = 1'b0;
   logic        p1 = 1'b0;
   logic        p2 = 1'b0;
   logic [2:0]  exp_q [$];
   string       name_q [$];
   logic [2:0]  ev [10];

   graph_capture #(
      .CHANNELS (5),
      .SAMPLES  (640),
      .X_SCALE  (2),
      .TRACE_H  (10),
      .Y0       (10),
      .PITCH    (30),
      .H_RES    (1280)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .x            (x),
      .y            (y),
      .sample_valid (sample_valid),
      .sample       (sample),
      .arm          (arm),
      .continuous   (continuous),
      .trig_mask    (trig_mask),
      .trig_value   (trig_value),
      .rgb_out      (rgb_out),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      p1 <= probe;
      p2 <= p1;
   end

   always @(negedge clk) begin
      if (p2) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pixel_underflow: rgb_out=%b with nothing expected", rgb_out);
         end else begin
            logic [2:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (rgb_out !== e) begin
               errors++;
               $display("FAIL %s: rgb_out=%b expected %b", n, rgb_out, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic feed(input logic [9:0] v);
      sample_valid = 1'b1;
      sample       = v;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   // scan x = 0..x_end-1 on line yy, probing the last ten pixels
   task automatic scan(input int yy, input int x_end, input string nm);
      for (int i = 0; i < x_end; i++) begin
         x = 11'(i);
         y = 10'(yy);
         if (i >= x_end - 10) begin
            probe = 1'b1;
            exp_q.push_back(ev[i - (x_end - 10)]);
            name_q.push_back($sformatf("%s x=%0d y=%0d", nm, i, yy));
         end else begin
            probe = 1'b0;
         end
         @(negedge clk);
      end
      probe = 1'b0;
      x     = '0;
      cyc(3);
   endtask

   task automatic fill(input logic [2:0] c);
      for (int i = 0; i < 10; i++) ev[i] = c;
   endtask

   initial begin
      rst          = 1'b0;
      x            = '0;
      y            = '0;
      sample_valid = 1'b0;
      sample       = '0;
      arm          = 1'b0;
      continuous   = 1'b0;
      trig_mask    = '0;
      trig_value   = '0;
      cyc(3);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_rgb", 32'(rgb_out), 0);
      rst = 1'b1;
      cyc(2);
      fill(3'b000);
      scan(19, 10, "idle_blank");

      // ramp capture, free trigger, with idle gaps
      pulse_arm();
      chk("armed_busy", 32'(busy), 1);
      chk("armed_done", 32'(done), 0);
      for (int k = 0; k < 640; k++) begin
         if (k % 7 == 3) begin
            sample = 10'h3FF;
            @(negedge clk);
         end
         if (k == 639) chk("ramp_done_early", 32'(done), 0);
         feed(10'(k));
      end
      chk("ramp_done", 32'(done), 1);
      chk("ramp_busy", 32'(busy), 0);

      ev = '{3'b010, 3'b010, 3'b111, 3'b000, 3'b111,
             3'b000, 3'b111, 3'b100, 3'b111, 3'b010};
      scan(19, 10, "ramp_bot");
      ev = '{3'b000, 3'b000, 3'b111, 3'b010, 3'b111,
             3'b000, 3'b111, 3'b100, 3'b111, 3'b000};
      scan(10, 10, "ramp_top");
      ev = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b111,
             3'b110, 3'b111, 3'b100, 3'b111, 3'b000};
      scan(15, 10, "ramp_mid");
      ev = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
             3'b000, 3'b000, 3'b000, 3'b111, 3'b010};
      scan(40, 10, "ramp_ch1");
      ev = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b111,
             3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
      scan(19, 1284, "ramp_edge");

      // masked trigger on ch0 == 01
      trig_mask  = 10'h003;
      trig_value = 10'h001;
      pulse_arm();
      for (int k = 0; k < 7; k++) feed(10'h000);
      chk("pretrig_busy", 32'(busy), 1);
      chk("pretrig_done", 32'(done), 0);
      feed(10'h02D);
      for (int k = 0; k < 638; k++) feed(10'h02C);
      chk("trig_done_early", 32'(done), 0);
      feed(10'h02C);
      chk("trig_done", 32'(done), 1);

      ev = '{3'b010, 3'b010, 3'b111, 3'b000, 3'b000,
             3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
      scan(10, 10, "trig_top");
      ev = '{3'b000, 3'b000, 3'b111, 3'b010, 3'b010,
             3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
      scan(19, 10, "trig_bot");
      for (int yy = 39; yy <= 50; yy++) begin
         fill((yy >= 40 && yy < 50) ? 3'b100 : 3'b000);
         scan(yy, 10, "ch1_x_band");
      end
      fill(3'b110);
      scan(75, 10, "ch2_z_mid");
      fill(3'b000);
      scan(74, 10, "ch2_z_off");

      // re-arm from HOLD blanks the display
      trig_mask = '0;
      pulse_arm();
      chk("rearm_busy", 32'(busy), 1);
      chk("rearm_done", 32'(done), 0);
      fill(3'b000);
      scan(40, 10, "rearm_blank");
      feed(10'h000);
      feed(10'h000);
      for (int k = 0; k < 638; k++) feed(10'h001);
      chk("edge_done", 32'(done), 1);
      ev = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b111,
             3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
      scan(19, 10, "edge_bot");
      ev = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b111,
             3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
      scan(10, 10, "edge_top");

      // continuous mode re-arms straight after completion
      continuous = 1'b1;
      @(negedge clk);
      chk("cont_busy", 32'(busy), 1);
      chk("cont_done", 32'(done), 0);
      fill(3'b000);
      scan(19, 10, "cont_blank");
      for (int k = 0; k < 640; k++) feed(10'h3FF);
      chk("cont_done_hold", 32'(done), 1);
      chk("cont_busy_hold", 32'(busy), 0);
      @(negedge clk);
      chk("cont_rearm_busy", 32'(busy), 1);
      chk("cont_rearm_done", 32'(done), 0);
      continuous = 1'b0;
      scan(15, 10, "cont_blank2");

      // reset in the middle of a capture
      for (int k = 0; k < 100; k++) feed(10'h3FF);
      rst = 1'b0;
      cyc(2);
      chk("midrst_rgb", 32'(rgb_out), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      fill(3'b000);
      scan(10, 10, "midrst_top");
      scan(45, 10, "midrst_ch1");
      scan(19, 1284, "midrst_line");
      for (int k = 0; k < 640; k++) feed(10'h3FF);
      chk("noarm_done", 32'(done), 0);
      chk("noarm_busy", 32'(busy), 0);

      cyc(4);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
